// File: rtl/writeback_pkg.sv
// Shared writeback definitions: default sizing and the queued multdiv result layout.
package writeback_pkg;

  localparam int WB_DEPTH        = 4;
  localparam int WB_STARVE_LIMIT = 4;

  // 37-bit queued result, destination register in the top bits
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Multdiv result queue: push lands in storage at the clock edge, head is read combinationally.
// The caller never pushes when full or pops when empty; pointers wrap modulo DEPTH.
module wb_fifo
  import writeback_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  push,
  input  wb_entry_t             push_dat,
  input  logic                  pop,
  output wb_entry_t             head_dat,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges single-cycle ALU results and queued multdiv results onto one register-file write port.
// Write visible one cycle after selection; ALU is stalled once the queue has waited STARVE_LIMIT cycles.
module writeback_arbiter
  import writeback_pkg::*;
#(
  parameter int DEPTH        = WB_DEPTH,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic                   clock,
  input  logic                   ctrl_reset,
  input  logic                   alu_valid,
  input  logic [4:0]             alu_rd,
  input  logic [31:0]            alu_data,
  input  logic                   md_valid,
  input  logic [4:0]             md_rd,
  input  logic [31:0]            md_data,
  output logic                   md_ready,
  output logic                   alu_stall,
  output logic                   ctrl_writeEnable,
  output logic [4:0]             ctrl_writeReg,
  output logic [31:0]            data_writeReg,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   protocol_err
);

  localparam int              CW    = $clog2(DEPTH) + 1;
  localparam int              SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   FULL  = CW'(DEPTH);
  localparam logic [SW-1:0]   LIMIT = SW'(STARVE_LIMIT);

  logic          alu_eff;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          sel_alu;
  logic [SW-1:0] starve_cnt;
  wb_entry_t     push_dat;
  wb_entry_t     head_dat;

  // Writes to x0 are architecturally void, so they neither write nor win arbitration
  assign alu_eff    = alu_valid && (alu_rd != 5'd0);
  assign fifo_empty = (fifo_count == '0);
  assign md_ready   = (fifo_count < FULL);
  assign alu_stall  = (starve_cnt == LIMIT);
  assign push       = md_valid && md_ready && (md_rd != 5'd0);
  assign push_dat   = '{rd: md_rd, data: md_data};

  always_comb begin
    sel_alu = 1'b0;
    pop     = 1'b0;
    if (alu_stall) begin
      pop = !fifo_empty;
    end else if (alu_eff) begin
      sel_alu = 1'b1;
    end else begin
      pop = !fifo_empty;
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .push       (push),
    .push_dat   (push_dat),
    .pop        (pop),
    .head_dat   (head_dat),
    .count      (fifo_count)
  );

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      starve_cnt   <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (pop || fifo_empty) starve_cnt <= '0;
      else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + SW'(1);
      if (alu_stall && alu_valid) protocol_err <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else begin
      ctrl_writeEnable <= sel_alu || pop;
      if (sel_alu) begin
        ctrl_writeReg <= alu_rd;
        data_writeReg <= alu_data;
      end else if (pop) begin
        ctrl_writeReg <= head_dat.rd;
        data_writeReg <= head_dat.data;
      end
    end
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4: multdiv result FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: cycles a non-empty FIFO may go undrained before ALU stall.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clock  in  1  sole clock; all state rising-edge.
REQ-005 ctrl_reset  in  1  asynchronous, active-low reset.
REQ-006 alu_valid  in  1  single-cycle ALU result present this cycle.
REQ-007 alu_rd  in  5  ALU destination register.
REQ-008 alu_data  in  32  ALU result.
REQ-009 md_valid  in  1  multdiv result offered.
REQ-010 md_rd  in  5  multdiv destination register.
REQ-011 md_data  in  32  multdiv result.
REQ-012 md_ready  out  1  FIFO can accept; transfer when md_valid and md_ready are both high.
REQ-013 alu_stall  out  1  upstream must hold alu_valid low next cycle.
REQ-014 ctrl_writeEnable  out  1  register-file write enable.
REQ-015 ctrl_writeReg  out  5  register-file write address.
REQ-016 data_writeReg  out  32  register-file write data.
REQ-017 fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy.
REQ-018 protocol_err  out  1  sticky: alu_valid seen while alu_stall high.

Function
REQ-019 Write-port outputs SHALL be registered: a result selected in cycle N appears on ctrl_writeEnable/ctrl_writeReg/data_writeReg in cycle N+1 for exactly one cycle.
REQ-020 md_ready SHALL equal (fifo_count < DEPTH), from registered state only; no push into a full FIFO even with a same-cycle pop.
REQ-021 Accepted multdiv results with md_rd != 0 SHALL be enqueued in order; md_rd == 0 SHALL be accepted and discarded.
REQ-022 ALU results with alu_rd == 0 SHALL be treated as alu_valid low (no write, no arbitration win).
REQ-023 Selection when alu_stall low: effective ALU valid wins; else FIFO head popped if non-empty; else ctrl_writeEnable low next cycle.
REQ-024 Selection when alu_stall high: FIFO head SHALL be popped; a concurrent alu_valid SHALL be dropped and protocol_err set.
REQ-025 Minimum multdiv latency SHALL be 2 cycles (enqueue cycle N, pop cycle N+1, write visible N+2); no bypass.
REQ-026 Starvation counter SHALL increment each cycle the FIFO is non-empty and not popped, saturate at STARVE_LIMIT, and clear on any pop or when empty.
REQ-027 alu_stall SHALL equal (starvation counter == STARVE_LIMIT), from registered state.
REQ-028 Simultaneous push and pop on non-full FIFO SHALL leave fifo_count unchanged; pointers wrap modulo DEPTH.
REQ-029 protocol_err SHALL remain high until reset.

Reset
REQ-030 Assertion of ctrl_reset low SHALL immediately clear FIFO pointers, fifo_count, starvation counter, protocol_err, ctrl_writeEnable, ctrl_writeReg, data_writeReg to 0; alu_stall 0; md_ready 1.
REQ-031 Reset mid-operation SHALL discard all queued results and any in-flight write; no write issued on the first clock after release.

Structure
REQ-032 Shared package writeback_pkg SHALL hold DEPTH and STARVE_LIMIT defaults and the 37-bit entry layout {rd[4:0], data[31:0]}.
REQ-033 FIFO storage/pointers SHALL be sub-module wb_fifo; arbitration, starvation and output registers stay in writeback_arbiter.

Verification
REQ-034 ALU only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF in cycle 0 -> cycle 1 ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF; cycle 2 enable=0.
REQ-035 Multdiv latency: md push rd=7, data=0x12345678 in cycle 0, no ALU -> write of reg 7 visible in cycle 2, fifo_count back to 0.
REQ-036 Fill/full: 5 md pushes back-to-back under continuous ALU traffic, DEPTH=4 -> md_ready low after 4th; 5th held; fifo_count=4.
REQ-037 Starvation: FIFO non-empty, alu_valid high 4 cycles -> alu_stall high in cycle 5; FIFO pops; alu_stall drops next cycle; a violating alu_valid sets protocol_err.
REQ-038 Register zero: alu_rd=0 with FIFO holding rd=3 -> rd=3 written next cycle; md_rd=0 push -> no write, fifo_count unchanged.
REQ-039 Reset mid-queue: 3 entries queued, ctrl_reset low -> all outputs at reset values immediately; no writes after release.
